// File: rtl/counter_pkg.sv
// counter_pkg: shared mode and FSM state encodings for mode_counter.
// Rev 1.0
`default_nettype none

package counter_pkg;

  localparam int MODE_W  = 2;
  localparam int STATE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    WRAP    = 2'b00,
    SAT     = 2'b01,
    ONESHOT = 2'b10,
    RSVD    = 2'b11
  } mode_e;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/counter_step.sv
// counter_step: combinational next count value and boundary detection.
// Rev 1.0
`default_nettype none

module counter_step
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] out,
  input  logic             up,
  input  mode_e            mode,
  output logic [WIDTH-1:0] nxt,
  output logic             hit_bound,
  output logic             ovf_evt
);

  logic [WIDTH-1:0] bound;
  logic [WIDTH-1:0] opposite;
  logic [WIDTH-1:0] stepped;
  logic             at_bound;

  always_comb begin
    bound     = up ? MAX_VAL : '0;
    opposite  = up ? '0 : MAX_VAL;
    stepped   = up ? (out + WIDTH'(1)) : (out - WIDTH'(1));
    at_bound  = (out == bound);
    nxt       = stepped;
    hit_bound = 1'b0;
    ovf_evt   = 1'b0;
    if (at_bound) begin
      // Stepping past the bound: SAT and ONESHOT hold, WRAP and RSVD jump across.
      ovf_evt = 1'b1;
      nxt     = ((mode == SAT) || (mode == ONESHOT)) ? out : opposite;
    end else begin
      hit_bound = (stepped == bound);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mode_counter_constraints.sv
// mode_counter_constraints: input assumptions for formal runs of mode_counter.
// Rev 1.0
`default_nettype none

module mode_counter_constraints #(
  parameter int WIDTH      = 4,
  parameter bit ALLOW_RSVD = 1'b0
) (
  input logic             clk,
  input logic             rst,
  input logic             start,
  input logic             stop,
  input logic             en,
  input logic             up,
  input logic             clr,
  input logic             load,
  input logic [WIDTH-1:0] load_val,
  input logic [1:0]       mode
);

  a_known_inputs : assume property (@(posedge clk) disable iff (!rst)
    !$isunknown({start, stop, en, up, clr, load, load_val, mode}));

  if (!ALLOW_RSVD) begin : g_no_rsvd
    a_no_rsvd_mode : assume property (@(posedge clk) disable iff (!rst) mode != 2'b11);
  end

endmodule

`default_nettype wire

// File: rtl/mode_counter.sv
// mode_counter: up/down counter with WRAP/SAT/ONESHOT modes and IDLE/RUN/DONE control FSM.
// Rev 1.0
`default_nettype none

module mode_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  state_e           state_q;
  state_e           state_d;
  mode_e            mode_sel;
  logic [WIDTH-1:0] out_d;
  logic             tc_d;
  logic             ovf_d;
  logic             step;
  logic [WIDTH-1:0] nxt;
  logic             hit_bound;
  logic             ovf_evt;
  logic [WIDTH-1:0] load_clamped;

  assign mode_sel     = mode_e'(mode);
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  counter_step #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_step (
    .out       (out),
    .up        (up),
    .mode      (mode_sel),
    .nxt       (nxt),
    .hit_bound (hit_bound),
    .ovf_evt   (ovf_evt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out;
    tc_d    = 1'b0;
    ovf_d   = ovf;
    step    = (state_q == RUN) && en && !clr && !load && !stop;

    if (clr) begin
      out_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      out_d = load_clamped;
    end else if (step) begin
      out_d = nxt;
      tc_d  = hit_bound;
      if (ovf_evt) begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A ONESHOT step that lands on, or pushes against, the bound finishes the run.
        if (stop) begin
          state_d = IDLE;
        end else if (step && (mode_sel == ONESHOT) && (hit_bound || ovf_evt)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (clr || load) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out  <= '0;
      tc   <= 1'b0;
      ovf  <= 1'b0;
      busy <= 1'b0;
    end else begin
      out  <= out_d;
      tc   <= tc_d;
      ovf  <= ovf_d;
      busy <= (state_d == RUN);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mode_counter.sv
// tb_mode_counter: table-driven directed bench for mode_counter (WIDTH=4, MAX_VAL=9).
// Rev 1.0
`default_nettype none

module tb_mode_counter;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       en;
  logic       up;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic [1:0] mode;
  logic [3:0] out;
  logic       tc;
  logic       ovf;
  logic       busy;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       start;
    logic       stop;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [3:0] lv;
    logic [1:0] mode;
    logic [3:0] e_out;
    logic       e_tc;
    logic       e_ovf;
    logic       e_busy;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  mode_counter #(
    .WIDTH   (4),
    .MAX_VAL (4'd9)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .out      (out),
    .tc       (tc),
    .ovf      (ovf),
    .busy     (busy)
  );

  mode_counter_constraints #(
    .WIDTH      (4),
    .ALLOW_RSVD (1'b1)
  ) u_cons (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .mode     (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, sp, e, u, cl, ld, input logic [3:0] lv,
                              input logic [1:0] md, input logic [3:0] eo,
                              input logic et, eov, eb);
    vec_t r;
    r.start = st; r.stop = sp; r.en = e; r.up = u; r.clr = cl; r.load = ld;
    r.lv = lv; r.mode = md; r.e_out = eo; r.e_tc = et; r.e_ovf = eov; r.e_busy = eb;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eo,
                           input logic et, eov, eb);
    check({tag, ".out"},  32'(out),  32'(eo));
    check({tag, ".tc"},   32'(tc),   32'(et));
    check({tag, ".ovf"},  32'(ovf),  32'(eov));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  task automatic drive(input logic st, sp, e, u, cl, ld, input logic [3:0] lv,
                       input logic [1:0] md);
    start = st; stop = sp; en = e; up = u; clr = cl; load = ld;
    load_val = lv; mode = md;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 4'd0, 2'd0);

    //           st sp en up cl ld  lv    md    out  tc ovf busy
    vecs[0]  = mk(0, 0, 0, 0, 0, 1, 4'd8, 2'd0, 4'd8, 0, 0, 0);
    vecs[1]  = mk(1, 0, 1, 1, 0, 0, 4'd0, 2'd0, 4'd8, 0, 0, 1);
    vecs[2]  = mk(0, 0, 1, 1, 0, 0, 4'd0, 2'd0, 4'd9, 1, 0, 1);
    vecs[3]  = mk(0, 0, 1, 1, 0, 0, 4'd0, 2'd0, 4'd0, 0, 1, 1);
    vecs[4]  = mk(0, 0, 1, 1, 0, 0, 4'd0, 2'd0, 4'd1, 0, 1, 1);
    vecs[5]  = mk(0, 0, 0, 1, 0, 0, 4'd0, 2'd0, 4'd1, 0, 1, 1);
    vecs[6]  = mk(0, 0, 1, 1, 0, 1, 4'd15, 2'd0, 4'd9, 0, 1, 1);
    vecs[7]  = mk(0, 0, 1, 1, 1, 1, 4'd4, 2'd0, 4'd0, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 4'd1, 2'd1, 4'd1, 0, 0, 1);
    vecs[9]  = mk(0, 0, 1, 0, 0, 0, 4'd0, 2'd1, 4'd0, 1, 0, 1);
    vecs[10] = mk(0, 0, 1, 0, 0, 0, 4'd0, 2'd1, 4'd0, 0, 1, 1);
    vecs[11] = mk(0, 0, 1, 1, 0, 0, 4'd0, 2'd1, 4'd1, 0, 1, 1);
    vecs[12] = mk(1, 1, 1, 1, 0, 0, 4'd0, 2'd1, 4'd1, 0, 1, 0);
    vecs[13] = mk(0, 0, 1, 1, 0, 0, 4'd0, 2'd1, 4'd1, 0, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 0, 4'd0, 2'd0, 4'd0, 0, 0, 0);
    vecs[15] = mk(1, 0, 0, 1, 0, 1, 4'd7, 2'd2, 4'd7, 0, 0, 1);
    vecs[16] = mk(0, 0, 1, 1, 0, 0, 4'd0, 2'd2, 4'd8, 0, 0, 1);
    vecs[17] = mk(0, 0, 1, 1, 0, 0, 4'd0, 2'd2, 4'd9, 1, 0, 0);
    vecs[18] = mk(1, 0, 1, 1, 0, 0, 4'd0, 2'd2, 4'd9, 0, 0, 0);
    vecs[19] = mk(0, 0, 1, 1, 0, 0, 4'd0, 2'd2, 4'd9, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 1, 0, 1, 4'd3, 2'd2, 4'd3, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 1, 0, 0, 4'd0, 2'd0, 4'd3, 0, 0, 1);
    vecs[22] = mk(0, 0, 0, 0, 0, 1, 4'd0, 2'd0, 4'd0, 0, 0, 1);
    vecs[23] = mk(0, 0, 1, 0, 0, 0, 4'd0, 2'd0, 4'd9, 0, 1, 1);
    vecs[24] = mk(0, 0, 1, 1, 0, 0, 4'd0, 2'd3, 4'd0, 0, 1, 1);
    vecs[25] = mk(0, 0, 0, 0, 0, 1, 4'd1, 2'd0, 4'd1, 0, 1, 1);
    vecs[26] = mk(0, 0, 1, 0, 0, 0, 4'd0, 2'd0, 4'd0, 1, 1, 1);
    vecs[27] = mk(0, 1, 1, 0, 0, 0, 4'd0, 2'd0, 4'd0, 0, 1, 0);

    // Reset state, checked while reset is still held.
    repeat (2) @(negedge clk);
    check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].en, vecs[i].up, vecs[i].clr,
            vecs[i].load, vecs[i].lv, vecs[i].mode);
      cycle();
      check_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_tc,
                vecs[i].e_ovf, vecs[i].e_busy);
    end

    // Asynchronous reset in the middle of a WRAP up-count at out=5.
    drive(0, 0, 0, 0, 1, 0, 4'd0, 2'd0);
    cycle();
    check_all("arst_clr", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1, 0, 1, 1, 0, 0, 4'd0, 2'd0);
    cycle();
    check_all("arst_start", 4'd0, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    repeat (5) cycle();
    check_all("arst_at5", 4'd5, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1 check_all("arst_async", 4'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    check_all("arst_held", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    check_all("arst_idle", 4'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cycle();
    check_all("arst_restart", 4'd0, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    cycle();
    check_all("arst_step", 4'd1, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the counter bit width (legal range 1..32).
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1, meaning the upper count bound (legal range 1..2**WIDTH-1).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning the reset: asynchronous assertion, active-low.
REQ-005 SHALL have port start, input, 1 bit, meaning move IDLE->RUN.
REQ-006 SHALL have port stop, input, 1 bit, meaning move RUN->IDLE.
REQ-007 SHALL have port en, input, 1 bit, meaning a count step is permitted this cycle.
REQ-008 SHALL have port up, input, 1 bit, meaning direction: 1 counts up, 0 counts down.
REQ-009 SHALL have port clr, input, 1 bit, meaning synchronous clear.
REQ-010 SHALL have port load, input, 1 bit, meaning synchronous load of load_val.
REQ-011 SHALL have port load_val, input, WIDTH bits, meaning the value to load.
REQ-012 SHALL have port mode, input, 2 bits, meaning 00 WRAP, 01 SAT, 10 ONESHOT, 11 reserved (behaves as WRAP).
REQ-013 SHALL have port out, output, WIDTH bits, meaning the registered count value.
REQ-014 SHALL have port tc, output, 1 bit, meaning a registered one-cycle terminal-count pulse.
REQ-015 SHALL have port ovf, output, 1 bit, meaning a sticky overflow/underflow flag.
REQ-016 SHALL have port busy, output, 1 bit, meaning the FSM is in RUN.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL apply transitions in this order: IDLE->RUN on start; RUN->IDLE on stop (stop wins over start); RUN->DONE when ONESHOT reaches its boundary; DONE->IDLE on clr or load; start ignored in DONE.
REQ-019 SHALL apply per-cycle priority clr > load > count step; clr sets out=0; load sets out=min(load_val, MAX_VAL).
REQ-020 SHALL take a count step only when state==RUN, en==1, clr==0, load==0, and stop==0.
REQ-021 SHALL step up by +1 and down by -1; the boundary is MAX_VAL for up and 0 for down.
REQ-022 SHALL, in WRAP, step from the boundary to the opposite bound (MAX_VAL->0, 0->MAX_VAL) and set ovf.
REQ-023 SHALL, in SAT, hold out at the boundary and set ovf when a step is attempted there.
REQ-024 SHALL, in ONESHOT, enter DONE in the same edge that out lands on the boundary; out then holds.
REQ-025 SHALL assert tc for exactly one cycle, coincident with out, whenever a count step lands out on the boundary; SHALL NOT assert tc on clr, load, or a SAT hold.
REQ-026 SHALL clear ovf only on clr or reset; load SHALL NOT clear ovf.
REQ-027 SHALL sample mode and up every cycle; a change takes effect on the next step with no extra latency.
REQ-028 SHALL give out a latency of 1 cycle from qualifying inputs; busy SHALL equal (state==RUN) registered.

Reset
REQ-029 SHALL, while rst==0, asynchronously force state=IDLE, out=0, tc=0, ovf=0, busy=0.
REQ-030 SHALL abort any count in progress on reset mid-operation; the first edge after rst deasserts evaluates inputs normally.

Structure
REQ-031 SHALL place mode_e (WRAP, SAT, ONESHOT, RSVD) and state_e (IDLE, RUN, DONE) in shared package counter_pkg.
REQ-032 SHALL place the combinational next-value and boundary logic in sub-module counter_step (inputs out, up, mode; outputs nxt, hit_bound, ovf_evt).
REQ-033 SHALL extend the companion formal constraints module with the new ports, constraining mode!=2'b11 by default.

Verification (WIDTH=4, MAX_VAL=9)
REQ-034 SHALL cover: WRAP, up, en=1 from out=8 -> out=9 with tc=1, then out=0 with ovf=1 and tc=0.
REQ-035 SHALL cover: SAT, down, from out=1 -> out=0 with tc=1; next step out stays 0, ovf=1, tc=0.
REQ-036 SHALL cover: ONESHOT, up, from out=7 -> out=9, state=DONE, busy=0; start ignored; load 3 -> IDLE with out=3.
REQ-037 SHALL cover: clr, load=1, and en all in the same cycle -> out=0, ovf=0, no step.
REQ-038 SHALL cover: load_val=15 -> out=9 (clamped), tc=0.
REQ-039 SHALL cover: rst asserted mid-RUN at out=5 -> out=0, state=IDLE, asynchronously before the next clk edge.
